// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Up/down modulo counter with count enable, synchronous parallel load,
//   programmable modulus (0..MAX), a clock-enable prescaler and a choice of
//   wrap or saturate behaviour at the count boundaries.
//
// Parameters
//   N         counter width in bits
//   MAX       highest count value (1 .. 2**N-1)
//   PRESCALE  enabled clk cycles per count step (>= 1)
//   SATURATE  0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   en        count enable; advances the prescaler
//   dir       count direction, 0 = down, 1 = up
//   load      synchronous parallel load (wins over a coincident step)
//   load_val  value to load, clamped to MAX
//   counter   registered count
//   tc        registered terminal-count pulse, aligned with the wrapped/held value
//   zero      counter == 0
//   at_max    counter == MAX
module updown_mod_counter #(
  parameter int N        = 5,
  parameter int MAX      = 2**N - 1,
  parameter int PRESCALE = 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] counter,
  output logic         tc,
  output logic         zero,
  output logic         at_max
);

  // Prescaler needs at least one bit even when every enabled cycle is a step.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [N-1:0]  MAX_V   = MAX[N-1:0];
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          step;
  logic          at_bnd;
  logic [N-1:0]  cnt_next;

  // Out-of-range load values are clamped so the counter never exceeds MAX.
  function automatic logic [N-1:0] clamp_max(input logic [N-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Next count for a step; boundary handling selected by SATURATE.
  function automatic logic [N-1:0] step_value(input logic [N-1:0] c,
                                               input logic         up);
    logic [N-1:0] r;
    if (up) begin
      if (c < MAX_V)   r = c + 1'b1;
      else if (SATURATE) r = MAX_V;
      else             r = '0;
    end else begin
      if (c != '0)     r = c - 1'b1;
      else if (SATURATE) r = '0;
      else             r = MAX_V;
    end
    return r;
  endfunction

  always_comb begin
    step     = en && !load && (presc == PS_LAST);
    at_bnd   = dir ? (counter == MAX_V) : (counter == '0);
    cnt_next = step_value(counter, dir);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter <= '0;
      presc   <= '0;
      tc      <= 1'b0;
    end else if (load) begin
      counter <= clamp_max(load_val);
      presc   <= '0;
      tc      <= 1'b0;
    end else if (step) begin
      counter <= cnt_next;
      presc   <= '0;
      tc      <= at_bnd;
    end else if (en) begin
      presc   <= presc + 1'b1;
      tc      <= 1'b0;
    end else begin
      tc      <= 1'b0;
    end
  end

  assign zero   = (counter == '0);
  assign at_max = (counter == MAX_V);

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter replacing the fixed-width free-running down counter in the counter library. It adds direction control, count enable, synchronous parallel load, a programmable modulus, an integrated clock-enable prescaler, and wrap or saturate boundary handling. Terminal-count and flag outputs allow it to sit directly under timers, baud generators and cascaded counter chains.

## Interface
Parameters:
- N, 5, counter width in bits; N ≥ 1.
- MAX, 2**N-1, highest count value; count range is 0..MAX; 1 ≤ MAX ≤ 2**N-1.
- PRESCALE, 1, number of enabled clk cycles per count step; PRESCALE ≥ 1; prescaler width is clog2(PRESCALE), minimum 1.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = hold at the boundary.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  count enable; advances the prescaler.
- dir  in  1  count direction: 0 = down, 1 = up; sampled on every step edge.
- load  in  1  synchronous parallel load.
- load_val  in  N  value to load; values above MAX are clamped to MAX.
- counter  out  N  registered count.
- tc  out  1  registered terminal-count pulse.
- zero  out  1  counter == 0 (combinational from the register).
- at_max  out  1  counter == MAX (combinational from the register).

## Operation
- Priority on each clk edge: reset, then load, then step, then hold.
- Reset (reset = 0, asynchronous) forces these values immediately:
  - counter = 0, prescaler = 0, tc = 0.
  - This gives zero = 1 and at_max = 0.
- Load (load = 1): counter = min(load_val, MAX), prescaler = 0, tc = 0. The en input is ignored that cycle.
- Prescaler (en = 1, load = 0):
  - The prescaler increments each cycle.
  - A step occurs on the edge where prescaler == PRESCALE-1; the prescaler returns to 0 on that edge.
  - With PRESCALE = 1, every enabled cycle is a step.
  - When en = 0, the prescaler and counter both hold and tc = 0.
- Step, down (dir = 0):
  - counter > 0: counter - 1.
  - counter == 0: becomes MAX if SATURATE = 0, stays 0 if SATURATE = 1.
- Step, up (dir = 1):
  - counter < MAX: counter + 1.
  - counter == MAX: becomes 0 if SATURATE = 0, stays MAX if SATURATE = 1.
- Boundary: the counter is at boundary when it is at 0 going down or at MAX going up.
- tc rule:
  - tc is set to 1 on any step edge taken while the counter is at boundary (either wrap or saturation hold).
  - tc is 0 on every other edge.
  - In saturate mode, tc therefore re-pulses on each further step attempt while the counter is held at the boundary.
- Arithmetic: all next-state arithmetic is done at N bits with explicit compares against MAX. The counter never holds a value greater than MAX, including when MAX < 2**N-1.

## Timing
- Step latency: the new counter value is visible 1 cycle after the step edge. With PRESCALE = P and en held high, steps land every P cycles.
- Load latency: counter = load_val one cycle after load is sampled. The first subsequent step comes P enabled cycles later.
- tc is asserted for exactly the single cycle following the boundary step edge, aligned with the wrapped or held counter value.
- A change on dir takes effect on the next step edge. No turnaround cycle is needed.
- A reset assertion mid-count clears all outputs without waiting for clk. Release is synchronous by assumption of the integrating design: the first step comes P enabled edges after release.
- If load and a step edge coincide, load wins and the pending step is discarded.

## Test plan
- Reset then wrap (N=5, MAX=31, P=1, SATURATE=0):
  - Stimulus: hold reset low 20 ns, then en=1, dir=0.
  - Required: counter sequence 0, 31, 30, 29, … with tc = 1 only in the cycle where counter = 31.
- Saturate down (SATURATE=1, MAX=31):
  - Stimulus: load 2, then en=1, dir=0.
  - Required: counter sequence 2, 1, 0, 0, 0; zero = 1 from the third value onward; tc high in both cycles where the held 0 is shown after a step.
- Modulus up (MAX=9):
  - Stimulus: load 7, en=1, dir=1.
  - Required: counter sequence 7, 8, 9, 0, 1; at_max = 1 at 9; tc = 1 with the 0; load_val = 20 loads 9.
- Prescaler (PRESCALE=3):
  - Stimulus: en=1, dir=1 from 0.
  - Required: counter increments every third cycle. Dropping en for 4 cycles mid-period stretches the gap by exactly 4 cycles.
- Load versus step (PRESCALE=3):
  - Stimulus: assert load with load_val = 5 on the edge where a step would occur.
  - Required: counter = 5 and no step; the next step occurs 3 enabled cycles later.
- Async reset mid-count:
  - Stimulus: drop reset between edges while counter = 17.
  - Required: counter = 0, tc = 0, zero = 1 before the next clk edge.
